// File: rtl/rmt_action_pkg.sv
// rmt_action_pkg: shared action-stage constants, container offset helper and ALU opcodes.
package rmt_action_pkg;

    localparam int DATA_WIDTH = 48;
    localparam int NUM_CONT   = 8;
    localparam int META_W     = 256;
    localparam int PHV_W      = NUM_CONT * DATA_WIDTH + META_W;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_SET  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SHL  = 4'd7,
        ALU_SHR  = 4'd8,
        ALU_COPY = 4'd9
    } alu_op_e;

    // Bit offset of container i inside the PHV; containers sit above the metadata tail.
    function automatic int cont_slice(input int i);
        return META_W + i * DATA_WIDTH;
    endfunction

endpackage

// File: rtl/phv_sync_fifo.sv
// phv_sync_fifo: synchronous-reset FIFO with first-word-fall-through read.
module phv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign count_d = (wr_ok && !rd_ok) ? count_q + 1'b1 :
                     (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    // Depth is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/phv_writeback_merge.sv
// phv_writeback_merge: buffers PHVs across the fixed ALU latency and merges ALU results
// into the masked containers on the way out.
module phv_writeback_merge
    import rmt_action_pkg::*;
#(
    parameter int STAGE_ID   = 0,
    parameter int DATA_WIDTH = rmt_action_pkg::DATA_WIDTH,
    parameter int NUM_CONT   = rmt_action_pkg::NUM_CONT,
    parameter int META_W     = rmt_action_pkg::META_W,
    parameter int FIFO_DEPTH = 4,
    parameter int PHV_W      = NUM_CONT * DATA_WIDTH + META_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PHV_W-1:0]                 phv_in,
    input  logic                             phv_in_valid,
    input  logic [NUM_CONT-1:0]              wb_mask_in,
    output logic                             phv_in_ready,
    input  logic [NUM_CONT*DATA_WIDTH-1:0]   container_in,
    input  logic [NUM_CONT-1:0]              container_in_valid,
    output logic [PHV_W-1:0]                 phv_out,
    output logic                             phv_out_valid,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             err_overflow,
    output logic                             err_underflow,
    output logic                             err_misalign
);
    localparam int EW = PHV_W + NUM_CONT;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STAGE_ID < 0)
        $error("phv_writeback_merge: FIFO_DEPTH must be a power of 2 >= 2");

    logic [EW-1:0]       head;
    logic [PHV_W-1:0]    head_phv, merged;
    logic [NUM_CONT-1:0] head_mask, sel;
    logic                full, empty, push, pop, rd_en;
    logic [PHV_W-1:0]    phv_out_q;
    logic                phv_out_valid_q, err_overflow_q, err_underflow_q, err_misalign_q;

    assign phv_in_ready = rst_n && !full;
    assign push         = phv_in_valid && phv_in_ready;
    assign pop          = |container_in_valid;
    assign rd_en        = pop && !empty;

    phv_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (push),
        .wr_data({phv_in, wb_mask_in}),
        .rd_en  (rd_en),
        .rd_data(head),
        .count  (fifo_count),
        .full   (full),
        .empty  (empty)
    );

    assign head_phv  = head[NUM_CONT +: PHV_W];
    assign head_mask = head[NUM_CONT-1:0];
    assign sel       = head_mask & container_in_valid;

    always_comb begin
        merged = head_phv;
        for (int i = 0; i < NUM_CONT; i++)
            merged[META_W + i*DATA_WIDTH +: DATA_WIDTH] = sel[i] ? container_in[i*DATA_WIDTH +: DATA_WIDTH]
                                                                 : head_phv[META_W + i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phv_out_q       <= '0;
            phv_out_valid_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_misalign_q  <= 1'b0;
        end else begin
            if (rd_en) phv_out_q <= merged;
            phv_out_valid_q <= rd_en;
            if (phv_in_valid && full) err_overflow_q <= 1'b1;
            if (pop && empty) err_underflow_q <= 1'b1;
            if (pop && !(&container_in_valid)) err_misalign_q <= 1'b1;
        end
    end

    assign phv_out       = phv_out_q;
    assign phv_out_valid = phv_out_valid_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign err_misalign  = err_misalign_q;

endmodule

// File: tb/tb_phv_writeback_merge.sv
// tb_phv_writeback_merge: directed self-checking bench for the writeback merge stage.
module tb_phv_writeback_merge;
    localparam int DW = 48, NC = 8, MW = 256, PW = NC*DW + MW;

    logic           clk = 0;
    logic           rst_n;
    logic [PW-1:0]  phv_in;
    logic           phv_in_valid;
    logic [NC-1:0]  wb_mask_in;
    logic           phv_in_ready;
    logic [NC*DW-1:0] container_in;
    logic [NC-1:0]  container_in_valid;
    logic [PW-1:0]  phv_out;
    logic           phv_out_valid;
    logic [2:0]     fifo_count;
    logic           err_overflow, err_underflow, err_misalign;

    int n_cmp = 0, n_fail = 0;

    phv_writeback_merge dut (
        .clk(clk), .rst_n(rst_n), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .wb_mask_in(wb_mask_in), .phv_in_ready(phv_in_ready), .container_in(container_in),
        .container_in_valid(container_in_valid), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
        .fifo_count(fifo_count), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] make_phv(input logic [7:0] s);
        logic [PW-1:0] p;
        p[MW-1:0] = {8{s, 24'hABCDEF}};
        for (int i = 0; i < NC; i++) p[MW + i*DW +: DW] = {8'hC0, s, 16'(i), 16'h5A5A};
        return p;
    endfunction

    function automatic logic [NC*DW-1:0] make_cin(input logic [7:0] s);
        logic [NC*DW-1:0] c;
        for (int i = 0; i < NC; i++) c[i*DW +: DW] = {8'hA1, s, 16'(i + 100), 16'h7777};
        return c;
    endfunction

    function automatic logic [PW-1:0] exp_merge(input logic [PW-1:0] p, input logic [NC-1:0] m,
                                                input logic [NC-1:0] v, input logic [NC*DW-1:0] c);
        logic [PW-1:0] r = p;
        for (int i = 0; i < NC; i++) if (m[i] && v[i]) r[MW + i*DW +: DW] = c[i*DW +: DW];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        phv_in_valid = 0;
        container_in_valid = '0;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 0;
        phv_in = make_phv(8'h01);
        wb_mask_in = '0;
        container_in = '0;
        tick();
        tick();
        n_cmp++;
        if (phv_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", phv_in_ready); end
        rst_n = 1;
        tick();
        n_cmp++;
        if ({phv_out, phv_out_valid, fifo_count, err_overflow, err_underflow, err_misalign} !== '0)
            begin n_fail++; $display("FAIL reset_outputs valid=%b count=%0d errs=%b%b%b", phv_out_valid, fifo_count, err_overflow, err_underflow, err_misalign); end
        n_cmp++;
        if (phv_in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b want=1", phv_in_ready); end
    endtask

    task automatic test_single_merge;
        logic [PW-1:0] p, e;
        logic [NC*DW-1:0] c;
        p = make_phv(8'h11);
        p[MW +: DW] = 48'h10;
        c = make_cin(8'h11);
        c[0 +: DW] = 48'h15;
        phv_in = p; wb_mask_in = 8'h01; phv_in_valid = 1;
        tick();
        phv_in_valid = 0;
        repeat (4) tick();
        container_in = c; container_in_valid = 8'hFF;
        tick();
        container_in_valid = '0;
        e = p;
        e[MW +: DW] = 48'h15;
        n_cmp++;
        if (phv_out_valid !== 1'b1 || phv_out !== e) begin n_fail++; $display("FAIL single_merge valid=%b cont0=%h want cont0=48'h15", phv_out_valid, phv_out[MW +: DW]); end
        tick();
        n_cmp++;
        if (phv_out_valid !== 1'b0 || phv_out !== e) begin n_fail++; $display("FAIL strobe_one_cycle valid=%b want=0 (data held)", phv_out_valid); end
    endtask

    task automatic test_no_mask;
        logic [PW-1:0] p;
        p = make_phv(8'h22);
        phv_in = p; wb_mask_in = 8'h00; phv_in_valid = 1;
        tick();
        phv_in_valid = 0;
        repeat (4) tick();
        container_in = make_cin(8'h22); container_in_valid = 8'hFF;
        tick();
        idle();
        n_cmp++;
        if (phv_out_valid !== 1'b1 || phv_out !== p) begin n_fail++; $display("FAIL no_mask_passthrough valid=%b out=%h want=%h", phv_out_valid, phv_out, p); end
        n_cmp++;
        if ({err_overflow, err_underflow, err_misalign} !== 3'b000) begin n_fail++; $display("FAIL no_mask_errs got=%b want=000", {err_overflow, err_underflow, err_misalign}); end
    endtask

    task automatic test_fill_overflow;
        logic [NC*DW-1:0] c;
        for (int k = 0; k < 4; k++) begin
            phv_in = make_phv(8'h30 + 8'(k)); wb_mask_in = 8'(1 << k); phv_in_valid = 1;
            tick();
        end
        phv_in_valid = 0;
        n_cmp++;
        if (phv_in_ready !== 1'b0 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_state ready=%b count=%0d want ready=0 count=4", phv_in_ready, fifo_count); end
        phv_in = make_phv(8'h3F); wb_mask_in = 8'hFF; phv_in_valid = 1;
        tick();
        phv_in_valid = 0;
        n_cmp++;
        if (err_overflow !== 1'b1 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL overflow ovf=%b count=%0d want ovf=1 count=4", err_overflow, fifo_count); end
        for (int k = 0; k < 4; k++) begin
            c = make_cin(8'h40 + 8'(k));
            container_in = c; container_in_valid = 8'hFF;
            tick();
            n_cmp++;
            if (phv_out_valid !== 1'b1 || phv_out !== exp_merge(make_phv(8'h30 + 8'(k)), 8'(1 << k), 8'hFF, c))
                begin n_fail++; $display("FAIL drain_order_%0d valid=%b out=%h", k, phv_out_valid, phv_out); end
        end
        idle();
        n_cmp++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL drain_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_underflow;
        do_reset();
        n_cmp++;
        if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_cleared got=%b want=0", err_overflow); end
        container_in = make_cin(8'h55); container_in_valid = 8'hFF;
        tick();
        idle();
        n_cmp++;
        if (phv_out_valid !== 1'b0 || err_underflow !== 1'b1 || fifo_count !== 3'd0)
            begin n_fail++; $display("FAIL underflow valid=%b unf=%b count=%0d want 0/1/0", phv_out_valid, err_underflow, fifo_count); end
    endtask

    task automatic test_back_to_back;
        logic [PW-1:0] old_p, new_p;
        logic [NC-1:0] old_m, new_m;
        logic [NC*DW-1:0] c;
        int bad = 0;
        do_reset();
        old_p = make_phv(8'hE0); old_m = 8'h5A;
        phv_in = old_p; wb_mask_in = old_m; phv_in_valid = 1;
        tick();
        for (int k = 0; k < 100; k++) begin
            new_p = make_phv(8'(k)); new_m = 8'(k * 37);
            c = make_cin(8'(k + 1));
            phv_in = new_p; wb_mask_in = new_m; phv_in_valid = 1;
            container_in = c; container_in_valid = 8'hFF;
            tick();
            n_cmp++;
            if (fifo_count !== 3'd1 || phv_out_valid !== 1'b1 || phv_out !== exp_merge(old_p, old_m, 8'hFF, c)) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL b2b_iter_%0d count=%0d valid=%b out=%h", k, fifo_count, phv_out_valid, phv_out);
            end
            old_p = new_p; old_m = new_m;
        end
        idle();
        tick();
        n_cmp++;
        if ({err_overflow, err_underflow, err_misalign} !== 3'b000) begin n_fail++; $display("FAIL b2b_errs got=%b want=000", {err_overflow, err_underflow, err_misalign}); end
        c = make_cin(8'hF0);
        container_in = c; container_in_valid = 8'hFF;
        tick();
        idle();
        n_cmp++;
        if (fifo_count !== 3'd0 || phv_out !== exp_merge(old_p, old_m, 8'hFF, c)) begin n_fail++; $display("FAIL b2b_last count=%0d out=%h", fifo_count, phv_out); end
    endtask

    task automatic test_misalign;
        logic [PW-1:0] p, e;
        logic [NC*DW-1:0] c;
        p = make_phv(8'h66);
        c = make_cin(8'h66);
        phv_in = p; wb_mask_in = 8'hFF; phv_in_valid = 1;
        tick();
        phv_in_valid = 0;
        repeat (4) tick();
        container_in = c; container_in_valid = 8'h0F;
        tick();
        idle();
        e = p;
        for (int i = 0; i < 4; i++) e[MW + i*DW +: DW] = c[i*DW +: DW];
        n_cmp++;
        if (phv_out_valid !== 1'b1 || phv_out !== e) begin n_fail++; $display("FAIL misalign_merge valid=%b out=%h want=%h", phv_out_valid, phv_out, e); end
        n_cmp++;
        if (err_misalign !== 1'b1 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL misalign_flag mis=%b unf=%b want 1/0", err_misalign, err_underflow); end
    endtask

    task automatic test_mid_reset;
        for (int k = 0; k < 2; k++) begin
            phv_in = make_phv(8'h70 + 8'(k)); wb_mask_in = 8'hFF; phv_in_valid = 1;
            tick();
        end
        phv_in_valid = 0;
        n_cmp++;
        if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL held_two got=%0d want=2", fifo_count); end
        rst_n = 0;
        tick();
        n_cmp++;
        if ({phv_out, phv_out_valid, fifo_count, err_overflow, err_underflow, err_misalign, phv_in_ready} !== '0)
            begin n_fail++; $display("FAIL mid_reset count=%0d valid=%b ready=%b errs=%b%b%b", fifo_count, phv_out_valid, phv_in_ready, err_overflow, err_underflow, err_misalign); end
        rst_n = 1;
        container_in = make_cin(8'h77); container_in_valid = 8'hFF;
        tick();
        idle();
        n_cmp++;
        if (err_underflow !== 1'b1 || phv_out_valid !== 1'b0 || fifo_count !== 3'd0)
            begin n_fail++; $display("FAIL post_reset_underflow unf=%b valid=%b count=%0d want 1/0/0", err_underflow, phv_out_valid, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single_merge();
        test_no_mask();
        test_fill_overflow();
        test_underflow();
        test_back_to_back();
        test_misalign();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
